// File: rtl/mcm_pkg.sv
// Shared definitions for the matrix-chain-multiplication sequencer:
// FSM state encoding, default sizing and table address packing.
package mcm_pkg;

    localparam int MCM_N_MAX = 8;
    localparam int MCM_IW    = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CLR   = 3'd2,
        S_ITER  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Table addresses are {row, col}, row in the upper half.
    function automatic logic [2*MCM_IW-1:0] pack_addr(input logic [MCM_IW-1:0] row,
                                                     input logic [MCM_IW-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/mcm_index_gen.sv
// Chain length / start / end / split counters for the DP table walk,
// plus the "last" flags the sequencer FSM branches on.
module mcm_index_gen #(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [IW-1:0] n_in,
    input  logic          adv_i,
    input  logic          next_l,
    input  logic          clr_cell,
    input  logic          adv_k,
    output logic [IW-1:0] i_q,
    output logic [IW-1:0] j_q,
    output logic [IW-1:0] k_q,
    output logic          k_last,
    output logic          i_last,
    output logic          l_last
);

    logic [IW-1:0] n_q;
    logic [IW-1:0] l_q;

    // The diagonal pass runs with L=1 so i_last (i == n-L+1) also ends it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= '0;
            l_q <= '0;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            if (load) begin
                n_q <= n_in;
                l_q <= IW'(1);
                i_q <= IW'(1);
            end
            if (adv_i)
                i_q <= i_q + IW'(1);
            if (next_l) begin
                l_q <= l_q + IW'(1);
                i_q <= IW'(1);
            end
            if (clr_cell) begin
                j_q <= i_q + l_q - IW'(1);
                k_q <= i_q;
            end
            if (adv_k)
                k_q <= k_q + IW'(1);
        end
    end

    assign k_last = (k_q == j_q - IW'(1));
    assign i_last = (i_q == n_q - l_q + IW'(1));
    assign l_last = (l_q == n_q);

endmodule

// File: rtl/mcm_sequencer.sv
// Control FSM of the matrix-chain-multiplication datapath: walks the DP table,
// feeds the min/argmin unit and writes its results back into the m/s tables.
module mcm_sequencer
    import mcm_pkg::*;
#(
    parameter int N_MAX = MCM_N_MAX,
    parameter int PW    = 8,
    parameter int DW    = 32,
    parameter int IW    = MCM_IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IW-1:0]   n,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [IW-1:0]   p_ra_i,
    output logic [IW-1:0]   p_ra_k,
    output logic [IW-1:0]   p_ra_j,
    input  logic [PW-1:0]   p_rd_i,
    input  logic [PW-1:0]   p_rd_k,
    input  logic [PW-1:0]   p_rd_j,
    output logic [2*IW-1:0] m_ra_a,
    output logic [2*IW-1:0] m_ra_b,
    input  logic [DW-1:0]   m_rd_a,
    input  logic [DW-1:0]   m_rd_b,
    output logic [PW-1:0]   cu_pi,
    output logic [PW-1:0]   cu_pk,
    output logic [PW-1:0]   cu_pj,
    output logic [DW-1:0]   cu_mki,
    output logic [DW-1:0]   cu_mkj1,
    output logic [DW-1:0]   cu_kc,
    output logic            cu_en,
    output logic            cu_clr,
    input  logic [DW-1:0]   cu_min,
    input  logic [DW-1:0]   cu_ko,
    output logic            m_we,
    output logic            s_we,
    output logic [2*IW-1:0] w_addr,
    output logic [DW-1:0]   m_wd,
    output logic [DW-1:0]   s_wd,
    output logic [2:0]      dbg_state
);

    state_t        state, state_nxt;
    logic          err_q;
    logic          n_bad;
    logic          load, adv_i, next_l, clr_cell, adv_k;
    logic [IW-1:0] i_q, j_q, k_q;
    logic          k_last, i_last, l_last;
    logic          in_init, in_iter, in_write;

    mcm_index_gen #(.IW(IW)) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .n_in     (n),
        .adv_i    (adv_i),
        .next_l   (next_l),
        .clr_cell (clr_cell),
        .adv_k    (adv_k),
        .i_q      (i_q),
        .j_q      (j_q),
        .k_q      (k_q),
        .k_last   (k_last),
        .i_last   (i_last),
        .l_last   (l_last)
    );

    assign n_bad = (n == '0) || (n > IW'(N_MAX));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv_i     = 1'b0;
        next_l    = 1'b0;
        clr_cell  = 1'b0;
        adv_k     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (n_bad) begin
                        state_nxt = S_DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (!i_last) begin
                    adv_i = 1'b1;
                end else if (l_last) begin
                    state_nxt = S_DONE;
                end else begin
                    next_l    = 1'b1;
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                clr_cell  = 1'b1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                adv_k = 1'b1;
                if (k_last)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (!i_last) begin
                    adv_i     = 1'b1;
                    state_nxt = S_CLR;
                end else if (!l_last) begin
                    next_l    = 1'b1;
                    state_nxt = S_CLR;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start)
                err_q <= n_bad;
        end
    end

    assign in_init  = (state == S_INIT);
    assign in_iter  = (state == S_ITER);
    assign in_write = (state == S_WRITE);

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign err       = err_q;
    assign dbg_state = state;

    // Read addresses and operands are only meaningful while iterating k;
    // elsewhere they are held at zero so idle/reset outputs stay quiet.
    assign p_ra_i  = in_iter ? i_q - IW'(1) : '0;
    assign p_ra_k  = in_iter ? k_q : '0;
    assign p_ra_j  = in_iter ? j_q : '0;
    assign m_ra_a  = in_iter ? pack_addr(i_q, k_q) : '0;
    assign m_ra_b  = in_iter ? pack_addr(k_q + IW'(1), j_q) : '0;
    assign cu_pi   = in_iter ? p_rd_i : '0;
    assign cu_pk   = in_iter ? p_rd_k : '0;
    assign cu_pj   = in_iter ? p_rd_j : '0;
    assign cu_mki  = in_iter ? m_rd_a : '0;
    assign cu_mkj1 = in_iter ? m_rd_b : '0;
    assign cu_kc   = in_iter ? DW'(k_q) : '0;
    assign cu_en   = in_iter;
    assign cu_clr  = (state == S_CLR);

    assign m_we   = in_init || in_write;
    assign s_we   = in_init || in_write;
    assign w_addr = in_init  ? pack_addr(i_q, i_q) :
                    in_write ? pack_addr(i_q, j_q) : '0;
    assign m_wd   = in_write ? cu_min : '0;
    assign s_wd   = in_write ? cu_ko : '0;

endmodule

// File: tb/tb_mcm_sequencer.sv
// Directed bench for mcm_sequencer with behavioural p/m/s tables and a
// min/argmin compute unit around it.
module tb_mcm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  n;
    logic        busy, done, err;
    logic [3:0]  p_ra_i, p_ra_k, p_ra_j;
    logic [7:0]  p_rd_i, p_rd_k, p_rd_j;
    logic [7:0]  m_ra_a, m_ra_b;
    logic [31:0] m_rd_a, m_rd_b;
    logic [7:0]  cu_pi, cu_pk, cu_pj;
    logic [31:0] cu_mki, cu_mkj1, cu_kc;
    logic        cu_en, cu_clr;
    logic [31:0] cu_min, cu_ko;
    logic        m_we, s_we;
    logic [7:0]  w_addr;
    logic [31:0] m_wd, s_wd;
    logic [2:0]  dbg_state;

    logic [7:0]  p_mem [0:15];
    logic [31:0] m_tab [0:255];
    logic [31:0] s_tab [0:255];
    logic [31:0] cost;

    logic [7:0]  log_addr[$];
    logic [31:0] log_m[$];
    logic [31:0] log_s[$];
    logic [7:0]  exp_q[$];
    logic [31:0] exp_m[$];
    logic [31:0] exp_s[$];

    int n_pass = 0;
    int n_chk  = 0;

    mcm_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .busy(busy), .done(done), .err(err),
        .p_ra_i(p_ra_i), .p_ra_k(p_ra_k), .p_ra_j(p_ra_j),
        .p_rd_i(p_rd_i), .p_rd_k(p_rd_k), .p_rd_j(p_rd_j),
        .m_ra_a(m_ra_a), .m_ra_b(m_ra_b), .m_rd_a(m_rd_a), .m_rd_b(m_rd_b),
        .cu_pi(cu_pi), .cu_pk(cu_pk), .cu_pj(cu_pj),
        .cu_mki(cu_mki), .cu_mkj1(cu_mkj1), .cu_kc(cu_kc),
        .cu_en(cu_en), .cu_clr(cu_clr), .cu_min(cu_min), .cu_ko(cu_ko),
        .m_we(m_we), .s_we(s_we), .w_addr(w_addr), .m_wd(m_wd), .s_wd(s_wd),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    assign p_rd_i = p_mem[p_ra_i];
    assign p_rd_k = p_mem[p_ra_k];
    assign p_rd_j = p_mem[p_ra_j];
    assign m_rd_a = m_tab[m_ra_a];
    assign m_rd_b = m_tab[m_ra_b];

    // compute unit model: keeps the first strict minimum
    assign cost = 32'(cu_pi) * 32'(cu_pk) * 32'(cu_pj) + cu_mki + cu_mkj1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cu_min <= '0;
            cu_ko  <= '0;
        end else if (cu_clr) begin
            cu_min <= 32'hFFFF_FFFF;
            cu_ko  <= '0;
        end else if (cu_en && cost < cu_min) begin
            cu_min <= cost;
            cu_ko  <= cu_kc;
        end
    end

    always @(posedge clk) begin
        if (!rst && m_we) begin
            m_tab[w_addr] <= m_wd;
            log_addr.push_back(w_addr);
            log_m.push_back(m_wd);
            log_s.push_back(s_we ? s_wd : 32'hDEAD_BEEF);
        end
        if (!rst && s_we)
            s_tab[w_addr] <= s_wd;
    end

    function automatic logic [7:0] ad(input int r, input int c);
        logic [3:0] rr, cc;
        rr = r[3:0];
        cc = c[3:0];
        return {rr, cc};
    endfunction

    // driver tasks
    task automatic set_p(input int a, input int b, input int c, input int d);
        p_mem[0] = a[7:0]; p_mem[1] = b[7:0]; p_mem[2] = c[7:0]; p_mem[3] = d[7:0];
    endtask

    task automatic run_seq(input logic [3:0] nv, input bit hold, output int bcyc,
                           output bit timeout, output logic errv);
        log_addr.delete(); log_m.delete(); log_s.delete();
        @(negedge clk);
        start = 1'b1;
        n = nv;
        @(negedge clk);
        if (hold) n = 4'd2;
        else start = 1'b0;
        bcyc = 0;
        timeout = 1'b1;
        errv = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                timeout = 1'b0;
                errv = err;
                break;
            end
            if (busy) bcyc++;
            @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        n = 4'd0;
    endtask

    task automatic load_chain_exp();
        exp_q.delete(); exp_m.delete(); exp_s.delete();
        exp_q = '{ad(1,1), ad(2,2), ad(3,3), ad(1,2), ad(2,3), ad(1,3)};
        exp_m = '{32'd0, 32'd0, 32'd0, 32'd1500, 32'd9000, 32'd4500};
        exp_s = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd2};
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n = 4'd0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err got %b%b want 00", done, err); else n_pass++;
        n_chk++; if ({m_we, s_we, cu_en, cu_clr} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {m_we, s_we, cu_en, cu_clr}); else n_pass++;
        n_chk++; if ({w_addr, p_ra_i, m_ra_b} !== 24'h0) $display("FAIL reset_addr got %h want 0", {w_addr, p_ra_i, m_ra_b}); else n_pass++;
        n_chk++; if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_chain();
        int bc; bit to; logic ev;
        set_p(10, 30, 5, 60);
        load_chain_exp();
        run_seq(4'd3, 1'b0, bc, to, ev);
        n_chk++; if (to) $display("FAIL chain_timeout no done seen"); else n_pass++;
        n_chk++; if (bc != 13) $display("FAIL chain_busy_cycles got %0d want 13", bc); else n_pass++;
        n_chk++; if (ev !== 1'b0) $display("FAIL chain_err got %b want 0", ev); else n_pass++;
        n_chk++; if (log_addr.size() != 6) $display("FAIL chain_nwrites got %0d want 6", log_addr.size()); else n_pass++;
        for (int x = 0; x < 6; x++) begin
            logic [7:0] ga; logic [31:0] gm, gs;
            ga = (x < log_addr.size()) ? log_addr[x] : 8'hFF;
            gm = (x < log_m.size()) ? log_m[x] : 32'hFFFF_FFFF;
            gs = (x < log_s.size()) ? log_s[x] : 32'hFFFF_FFFF;
            n_chk++; if (ga !== exp_q[x]) $display("FAIL chain_addr[%0d] got %h want %h", x, ga, exp_q[x]); else n_pass++;
            n_chk++; if (gm !== exp_m[x]) $display("FAIL chain_m[%0d] got %0d want %0d", x, gm, exp_m[x]); else n_pass++;
            n_chk++; if (gs !== exp_s[x]) $display("FAIL chain_s[%0d] got %0d want %0d", x, gs, exp_s[x]); else n_pass++;
        end
    endtask

    task automatic test_tie();
        int bc; bit to; logic ev;
        set_p(1, 1, 1, 1);
        run_seq(4'd3, 1'b0, bc, to, ev);
        n_chk++; if (to) $display("FAIL tie_timeout no done seen"); else n_pass++;
        n_chk++; if (m_tab[ad(1,3)] !== 32'd2) $display("FAIL tie_m13 got %0d want 2", m_tab[ad(1,3)]); else n_pass++;
        n_chk++; if (s_tab[ad(1,3)] !== 32'd1) $display("FAIL tie_s13 got %0d want 1", s_tab[ad(1,3)]); else n_pass++;
        n_chk++; if (s_tab[ad(2,3)] !== 32'd2) $display("FAIL tie_s23 got %0d want 2", s_tab[ad(2,3)]); else n_pass++;
        n_chk++; if (m_tab[ad(1,2)] !== 32'd1) $display("FAIL tie_m12 got %0d want 1", m_tab[ad(1,2)]); else n_pass++;
    endtask

    task automatic test_edges();
        int bc; bit to; logic ev;
        run_seq(4'd0, 1'b0, bc, to, ev);
        n_chk++; if (to || bc != 0) $display("FAIL n0_timing got busy=%0d to=%b want 0 0", bc, to); else n_pass++;
        n_chk++; if (ev !== 1'b1) $display("FAIL n0_err got %b want 1", ev); else n_pass++;
        n_chk++; if (log_addr.size() != 0) $display("FAIL n0_writes got %0d want 0", log_addr.size()); else n_pass++;
        n_chk++; if (err !== 1'b1) $display("FAIL n0_err_hold got %b want 1", err); else n_pass++;
        run_seq(4'd9, 1'b0, bc, to, ev);
        n_chk++; if (to || bc != 0) $display("FAIL n9_timing got busy=%0d to=%b want 0 0", bc, to); else n_pass++;
        n_chk++; if (ev !== 1'b1) $display("FAIL n9_err got %b want 1", ev); else n_pass++;
        n_chk++; if (log_addr.size() != 0) $display("FAIL n9_writes got %0d want 0", log_addr.size()); else n_pass++;
        run_seq(4'd1, 1'b0, bc, to, ev);
        n_chk++; if (to || bc != 1) $display("FAIL n1_busy got %0d to=%b want 1 0", bc, to); else n_pass++;
        n_chk++; if (ev !== 1'b0) $display("FAIL n1_err got %b want 0", ev); else n_pass++;
        n_chk++; if (log_addr.size() != 1) $display("FAIL n1_nwrites got %0d want 1", log_addr.size()); else n_pass++;
        n_chk++; if (log_addr.size() > 0 && (log_addr[0] !== 8'h11 || log_m[0] !== 32'd0 || log_s[0] !== 32'd0))
            $display("FAIL n1_write got %h/%0d/%0d want 11/0/0", log_addr[0], log_m[0], log_s[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bc; bit to; logic ev; bit hit;
        set_p(10, 30, 5, 60);
        log_addr.delete(); log_m.delete(); log_s.delete();
        @(negedge clk);
        start = 1'b1; n = 4'd3;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (log_addr.size() == 5 && dbg_state == 3'd3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_chk++; if (!hit || cu_en !== 1'b1) $display("FAIL rmid_reach got hit=%b cu_en=%b want 1 1", hit, cu_en); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if ({busy, done, cu_en, cu_clr, m_we, s_we} !== 6'b0) $display("FAIL rmid_strobes got %b want 0", {busy, done, cu_en, cu_clr, m_we, s_we}); else n_pass++;
        n_chk++; if ({p_ra_k, m_ra_a, cu_kc, cu_pi, w_addr} !== 60'h0) $display("FAIL rmid_data got %h want 0", {p_ra_k, m_ra_a, cu_kc, cu_pi, w_addr}); else n_pass++;
        n_chk++; if (dbg_state !== 3'd0) $display("FAIL rmid_state got %0d want 0", dbg_state); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (log_addr.size() != 5) $display("FAIL rmid_nowrite got %0d want 5", log_addr.size()); else n_pass++;
        set_p(7, 3, 11, 60);
        run_seq(4'd2, 1'b0, bc, to, ev);
        n_chk++; if (to || bc != 5) $display("FAIL rmid_rerun_busy got %0d to=%b want 5 0", bc, to); else n_pass++;
        n_chk++; if (m_tab[ad(1,2)] !== 32'd231) $display("FAIL rmid_m12 got %0d want 231", m_tab[ad(1,2)]); else n_pass++;
        n_chk++; if (s_tab[ad(1,2)] !== 32'd1) $display("FAIL rmid_s12 got %0d want 1", s_tab[ad(1,2)]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bc; bit to; logic ev;
        set_p(10, 30, 5, 60);
        load_chain_exp();
        run_seq(4'd3, 1'b1, bc, to, ev);
        n_chk++; if (to || bc != 13) $display("FAIL b2b_busy got %0d to=%b want 13 0", bc, to); else n_pass++;
        n_chk++; if (busy !== 1'b0 || dbg_state !== 3'd0) $display("FAIL b2b_done_start got busy=%b st=%0d want 0 0", busy, dbg_state); else n_pass++;
        n_chk++; if (log_addr.size() != 6) $display("FAIL b2b_nwrites got %0d want 6", log_addr.size()); else n_pass++;
        for (int x = 0; x < 6; x++) begin
            logic [7:0] ga; logic [31:0] gm;
            ga = (x < log_addr.size()) ? log_addr[x] : 8'hFF;
            gm = (x < log_m.size()) ? log_m[x] : 32'hFFFF_FFFF;
            n_chk++; if (ga !== exp_q[x] || gm !== exp_m[x])
                $display("FAIL b2b_write[%0d] got %h/%0d want %h/%0d", x, ga, gm, exp_q[x], exp_m[x]); else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] mm [0:8][0:8];
        logic [31:0] ss [0:8][0:8];
        logic [31:0] best, c;
        int bk, bc; bit to; logic ev;
        for (int x = 0; x <= 8; x++) p_mem[x] = 8'($urandom_range(1, 20));
        exp_q.delete(); exp_m.delete(); exp_s.delete();
        for (int i = 1; i <= 8; i++) begin
            mm[i][i] = 0; ss[i][i] = 0;
            exp_q.push_back(ad(i, i)); exp_m.push_back(0); exp_s.push_back(0);
        end
        for (int l = 2; l <= 8; l++) begin
            for (int i = 1; i <= 9 - l; i++) begin
                int j;
                j = i + l - 1;
                best = 32'hFFFF_FFFF; bk = 0;
                for (int k = i; k < j; k++) begin
                    c = mm[i][k] + mm[k+1][j] + 32'(p_mem[i-1]) * 32'(p_mem[k]) * 32'(p_mem[j]);
                    if (c < best) begin best = c; bk = k; end
                end
                mm[i][j] = best; ss[i][j] = 32'(bk);
                exp_q.push_back(ad(i, j)); exp_m.push_back(best); exp_s.push_back(32'(bk));
            end
        end
        run_seq(4'd8, 1'b0, bc, to, ev);
        n_chk++; if (to || bc != 148) $display("FAIL rnd_busy got %0d to=%b want 148 0", bc, to); else n_pass++;
        n_chk++; if (log_addr.size() != exp_q.size()) $display("FAIL rnd_nwrites got %0d want %0d", log_addr.size(), exp_q.size()); else n_pass++;
        for (int x = 0; x < exp_q.size(); x++) begin
            logic [7:0] ga; logic [31:0] gm, gs;
            ga = (x < log_addr.size()) ? log_addr[x] : 8'hFF;
            gm = (x < log_m.size()) ? log_m[x] : 32'hFFFF_FFFF;
            gs = (x < log_s.size()) ? log_s[x] : 32'hFFFF_FFFF;
            n_chk++; if (ga !== exp_q[x]) $display("FAIL rnd_addr[%0d] got %h want %h", x, ga, exp_q[x]); else n_pass++;
            n_chk++; if (gm !== exp_m[x] || gs !== exp_s[x])
                $display("FAIL rnd_ms[%0d] got %0d/%0d want %0d/%0d", x, gm, gs, exp_m[x], exp_s[x]); else n_pass++;
        end
    endtask

    initial begin
        for (int x = 0; x < 16; x++) p_mem[x] = 8'd0;
        for (int x = 0; x < 256; x++) begin
            m_tab[x] = 32'd0;
            s_tab[x] = 32'd0;
        end
        test_reset();
        test_chain();
        test_tie();
        test_edges();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
